// File: rtl/bsg_circular_ptr_reader_if.sv
// Handshake bundle between a ring-buffer writer/consumer and the circular read-pointer tracker.
// The master side drives the requests. The slave side (the tracker) returns the grant and the pointer/occupancy state.
interface bsg_circular_ptr_reader_if #(
    parameter int slots_p   = 128,
    parameter int max_add_p = 10
);
    localparam int ptr_w = (slots_p > 1) ? $clog2(slots_p) : 1;
    localparam int add_w = $clog2(max_add_p + 1);
    localparam int cnt_w = $clog2(slots_p + 1);

    logic [add_w-1:0] wr_add_i;
    logic [add_w-1:0] deq_i;
    logic [add_w-1:0] deq_grant_o;
    logic [ptr_w-1:0] rptr_o;
    logic [ptr_w-1:0] wptr_o;
    logic [cnt_w-1:0] count_o;
    logic             empty_o;
    logic             full_o;
    logic             err_o;

    modport master (
        output wr_add_i, deq_i,
        input  deq_grant_o, rptr_o, wptr_o, count_o, empty_o, full_o, err_o
    );

    modport slave (
        input  wr_add_i, deq_i,
        output deq_grant_o, rptr_o, wptr_o, count_o, empty_o, full_o, err_o
    );
endinterface

// File: rtl/bsg_circular_ptr_reader.sv
// Read-side tracker for a circular buffer. It shadows the writer's pointer, keeps the occupancy count,
// grants dequeues and latches a sticky error when it sees illegal or overflowing requests.
module bsg_circular_ptr_reader #(
    parameter int slots_p   = 128,
    parameter int max_add_p = 10
) (
    input  logic                     clk,
    input  logic                     reset_i,
    bsg_circular_ptr_reader_if.slave bus
);
    localparam int ptr_w     = (slots_p > 1) ? $clog2(slots_p) : 1;
    localparam int add_w     = $clog2(max_add_p + 1);
    localparam int cnt_w     = $clog2(slots_p + 1);
    localparam int ptr_ext_w = ptr_w + 1;
    localparam int cnt_ext_w = cnt_w + 1;

    localparam logic [add_w-1:0]     max_add_lp   = add_w'(max_add_p);
    localparam logic [ptr_ext_w-1:0] slots_ptr_lp = ptr_ext_w'(slots_p);
    localparam logic [cnt_ext_w-1:0] slots_cnt_lp = cnt_ext_w'(slots_p);
    localparam logic [cnt_w-1:0]     slots_full_lp = cnt_w'(slots_p);

    logic [ptr_w-1:0] rptr_r, rptr_n;
    logic [ptr_w-1:0] wptr_r, wptr_n;
    logic [cnt_w-1:0] count_r, count_n;
    logic             err_r, err_n;

    logic                 deq_bad;
    logic                 wr_bad;
    logic                 overflow;
    logic [add_w-1:0]     grant;
    logic [add_w-1:0]     wr_acc;
    logic [cnt_ext_w-1:0] post_sum;

    // Advance by at most slots_p: one conditional subtract gives the modulus for any slots_p.
    function automatic logic [ptr_w-1:0] ptr_adv(input logic [ptr_w-1:0] p,
                                                 input logic [add_w-1:0] n);
        logic [ptr_ext_w-1:0] s;
        s = ptr_ext_w'(p) + ptr_ext_w'(n);
        if (s >= slots_ptr_lp) begin
            s = s - slots_ptr_lp;
        end
        return ptr_w'(s);
    endfunction

    always_comb begin
        deq_bad  = (bus.deq_i > max_add_lp);
        wr_bad   = (bus.wr_add_i > max_add_lp);
        grant    = '0;
        wr_acc   = '0;
        overflow = 1'b0;
        post_sum = '0;

        // Grant looks only at registered occupancy, so a same-cycle write is never bypassed.
        if (!reset_i && !deq_bad) begin
            grant = (cnt_w'(bus.deq_i) <= count_r) ? bus.deq_i : add_w'(count_r);
        end

        post_sum = cnt_ext_w'(count_r) - cnt_ext_w'(grant) + cnt_ext_w'(bus.wr_add_i);
        overflow = !wr_bad && (post_sum > slots_cnt_lp);
        if (!wr_bad && !overflow) begin
            wr_acc = bus.wr_add_i;
        end

        rptr_n  = ptr_adv(rptr_r, grant);
        wptr_n  = ptr_adv(wptr_r, wr_acc);
        count_n = count_r - cnt_w'(grant) + cnt_w'(wr_acc);
        err_n   = err_r | deq_bad | wr_bad | overflow;
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            rptr_r  <= '0;
            wptr_r  <= '0;
            count_r <= '0;
            err_r   <= 1'b0;
        end else begin
            rptr_r  <= rptr_n;
            wptr_r  <= wptr_n;
            count_r <= count_n;
            err_r   <= err_n;
        end
    end

    assign bus.deq_grant_o = grant;
    assign bus.rptr_o      = rptr_r;
    assign bus.wptr_o      = wptr_r;
    assign bus.count_o     = count_r;
    assign bus.empty_o     = (count_r == '0);
    assign bus.full_o      = (count_r == slots_full_lp);
    assign bus.err_o       = err_r;
endmodule
